// File: rtl/selector_four.sv
// 4:1 bit selector with registered copies, a change pulse and optional per-channel select counters.
// Counters are built only when SELECTOR_FOUR_STATS_EN is defined; otherwise cnt is tied to 0.
module selector_four #(
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in,
  input  logic [1:0]         sel,
  input  logic               clr,
  output logic               out,
  output logic               out_q,
  output logic [1:0]         sel_q,
  output logic               chg,
  output logic [4*CNT_W-1:0] cnt
);

  logic chg_d;

  assign out   = in[sel];
  assign chg_d = (out != out_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= RESET_VAL;
      sel_q <= 2'b00;
      chg   <= 1'b0;
    end else begin
      out_q <= out;
      sel_q <= sel;
      chg   <= chg_d;
    end
  end

`ifdef SELECTOR_FOUR_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Clear has priority; the channel credited is the one already latched in sel_q.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if ((sel_q == 2'(gi)) && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign cnt        = '0;
`endif

endmodule

// File: tb/tb_selector_four.sv
// Randomized self-checking bench for selector_four against a behavioural model.
module tb_selector_four;

  localparam logic RESET_VAL = 1'b1;
  localparam int   CNT_W     = 8;
  localparam int   CNT_MAX   = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst;
  logic [3:0]         din;
  logic [1:0]         sel_s;
  logic               clr;
  logic               out_w;
  logic               out_q_w;
  logic [1:0]         sel_q_w;
  logic               chg_w;
  logic [4*CNT_W-1:0] cnt_w;

  int checks;
  int errors;

  // Model state
  logic m_out_q;
  int   m_sel_q;
  logic m_chg;
  int   m_cnt [4];

  selector_four #(.RESET_VAL(RESET_VAL), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (din),
    .sel  (sel_s),
    .clr  (clr),
    .out  (out_w),
    .out_q(out_q_w),
    .sel_q(sel_q_w),
    .chg  (chg_w),
    .cnt  (cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic sel_bit(input logic [3:0] d, input logic [1:0] s);
    int v;
    v = (int'(d) >> int'(s)) % 2;
    return (v == 1);
  endfunction

  function automatic logic [4*CNT_W-1:0] exp_cnt();
    logic [4*CNT_W-1:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    return v;
  endfunction

  task automatic model_reset();
    m_out_q = RESET_VAL;
    m_sel_q = 0;
    m_chg   = 1'b0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Advance one clock: model computed from pre-edge inputs, then wait to the next falling edge.
  task automatic tick();
    logic o;
    o = sel_bit(din, sel_s);
    if (!rst) begin
`ifdef SELECTOR_FOUR_STATS_EN
      if (clr) begin
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (m_cnt[m_sel_q] < CNT_MAX) begin
        m_cnt[m_sel_q] = m_cnt[m_sel_q] + 1;
      end
`endif
      m_chg   = (o != m_out_q);
      m_out_q = o;
      m_sel_q = int'(sel_s);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 4'($urandom_range(0, 15)); sel_s = 2'($urandom_range(0, 3)); clr = 1'b0;
    #2;
    model_reset();
    checks++; if (out_q_w !== RESET_VAL) begin errors++; $display("FAIL reset_out_q: got %b want %b", out_q_w, RESET_VAL); end
    checks++; if (sel_q_w !== 2'b00) begin errors++; $display("FAIL reset_sel_q: got %b want 00", sel_q_w); end
    checks++; if (chg_w !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b want 0", chg_w); end
    checks++; if (cnt_w !== '0) begin errors++; $display("FAIL reset_cnt: got %h want 0", cnt_w); end
    checks++; if (out_w !== sel_bit(din, sel_s)) begin errors++; $display("FAIL reset_out: got %b want %b", out_w, sel_bit(din, sel_s)); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: out_q=%b sel_q=%b chg=%b cnt=%h", out_q_w, sel_q_w, chg_w, cnt_w);
  endtask

  task automatic test_comb_select();
    logic [3:0] pat;
    pat = 4'b1010;
    din = pat;
    for (int s = 0; s < 4; s++) begin
      sel_s = 2'(s);
      #1;
      checks++;
      if (out_w !== ((s % 2) == 1)) begin
        errors++; $display("FAIL comb_sel%0d: got %b want %b", s, out_w, (s % 2) == 1);
      end
      $display("comb: in=%b sel=%0d out=%b", din, s, out_w);
      for (int c = 0; c < 10; c++) tick();
    end
    for (int i = 0; i < 12; i++) begin
      din = 4'($urandom_range(0, 15)); sel_s = 2'($urandom_range(0, 3));
      #1;
      checks++;
      if (out_w !== sel_bit(din, sel_s)) begin
        errors++; $display("FAIL comb_rand: in=%b sel=%0d got %b want %b", din, sel_s, out_w, sel_bit(din, sel_s));
      end
      tick();
    end
  endtask

  task automatic test_registered_chg();
    din = 4'b1010; sel_s = 2'b00;
    tick(); tick();
    sel_s = 2'b01;
    tick();
    checks++; if (out_q_w !== 1'b1) begin errors++; $display("FAIL reg_out_q: got %b want 1", out_q_w); end
    checks++; if (chg_w !== 1'b1) begin errors++; $display("FAIL reg_chg_pulse: got %b want 1", chg_w); end
    checks++; if (sel_q_w !== 2'b01) begin errors++; $display("FAIL reg_sel_q: got %b want 01", sel_q_w); end
    $display("registered: out_q=%b chg=%b sel_q=%b", out_q_w, chg_w, sel_q_w);
    tick();
    checks++; if (chg_w !== 1'b0) begin errors++; $display("FAIL reg_chg_drop: got %b want 0", chg_w); end
    checks++; if (cnt_w !== exp_cnt()) begin errors++; $display("FAIL reg_cnt: got %h want %h", cnt_w, exp_cnt()); end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 60; i++) begin
      din   = 4'($urandom_range(0, 15));
      sel_s = 2'($urandom_range(0, 3));
      clr   = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (out_q_w !== m_out_q || sel_q_w !== 2'(m_sel_q) || chg_w !== m_chg || cnt_w !== exp_cnt()) begin
        errors++;
        $display("FAIL rand_cycle%0d: got out_q=%b sel_q=%b chg=%b cnt=%h want out_q=%b sel_q=%0d chg=%b cnt=%h",
                 i, out_q_w, sel_q_w, chg_w, cnt_w, m_out_q, m_sel_q, m_chg, exp_cnt());
      end
      $display("rand: in=%b sel=%0d clr=%b out_q=%b chg=%b cnt=%h", din, sel_s, clr, out_q_w, chg_w, cnt_w);
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    din = 4'b0000; sel_s = 2'b11;
    tick(); tick();
    checks++; if (out_q_w !== 1'b0) begin errors++; $display("FAIL areset_pre_out_q: got %b want 0", out_q_w); end
    #1;
    rst = 1'b1;
    din = 4'b0100; sel_s = 2'b10;
    #1;
    model_reset();
    checks++; if (out_q_w !== RESET_VAL) begin errors++; $display("FAIL areset_out_q: got %b want %b", out_q_w, RESET_VAL); end
    checks++; if (sel_q_w !== 2'b00) begin errors++; $display("FAIL areset_sel_q: got %b want 00", sel_q_w); end
    checks++; if (chg_w !== 1'b0) begin errors++; $display("FAIL areset_chg: got %b want 0", chg_w); end
    checks++; if (cnt_w !== '0) begin errors++; $display("FAIL areset_cnt: got %h want 0", cnt_w); end
    checks++; if (out_w !== 1'b1) begin errors++; $display("FAIL areset_out: got %b want 1", out_w); end
    $display("async reset: out_q=%b sel_q=%b chg=%b cnt=%h out=%b", out_q_w, sel_q_w, chg_w, cnt_w, out_w);
    #1;
    rst = 1'b0;
    din = 4'b0000;
    tick();
    checks++; if (out_q_w !== 1'b0 || chg_w !== 1'b1) begin
      errors++; $display("FAIL areset_resume: got out_q=%b chg=%b want out_q=0 chg=1", out_q_w, chg_w);
    end
    checks++; if (sel_q_w !== 2'b10 || cnt_w !== exp_cnt()) begin
      errors++; $display("FAIL areset_resume_regs: got sel_q=%b cnt=%h want sel_q=10 cnt=%h", sel_q_w, cnt_w, exp_cnt());
    end
  endtask

  task automatic test_saturation();
    logic [4*CNT_W-1:0] want;
    din = 4'($urandom_range(0, 15)); sel_s = 2'b10; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 300; c++) tick();
`ifdef SELECTOR_FOUR_STATS_EN
    want = {8'd0, 8'd255, 8'd0, 8'd0};
`else
    want = '0;
`endif
    checks++; if (cnt_w !== want) begin errors++; $display("FAIL saturation_const: got %h want %h", cnt_w, want); end
    checks++; if (cnt_w !== exp_cnt()) begin errors++; $display("FAIL saturation_model: got %h want %h", cnt_w, exp_cnt()); end
    $display("saturation: cnt=%h", cnt_w);
  endtask

  task automatic test_clear_priority();
    sel_s = 2'b01;
    for (int c = 0; c < 5; c++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (cnt_w !== '0) begin errors++; $display("FAIL clear_wins: got %h want 0", cnt_w); end
    tick();
`ifdef SELECTOR_FOUR_STATS_EN
    want_one: begin
      logic [4*CNT_W-1:0] w1;
      w1 = '0; w1[CNT_W +: CNT_W] = CNT_W'(1);
      checks++; if (cnt_w !== w1) begin errors++; $display("FAIL clear_restart: got %h want %h", cnt_w, w1); end
    end
`endif
    checks++; if (cnt_w !== exp_cnt()) begin errors++; $display("FAIL clear_model: got %h want %h", cnt_w, exp_cnt()); end
    $display("clear: cnt=%h", cnt_w);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; clr = 1'b0; din = 4'b0; sel_s = 2'b0;
    model_reset();
    test_reset();
    test_comb_select();
    test_registered_chg();
    test_random_traffic();
    test_async_reset();
    test_saturation();
    test_clear_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/selector_four.md
SELECTOR_FOUR -- requirements
Module: selector_four

Interface
REQ-001 Parameter: RESET_VAL, default 1'b0, reset value of out_q.
REQ-002 Parameter: CNT_W, default 8, width of each per-channel select counter.
REQ-003 Port: clk  input  1  single clock; all registers update on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: in  input  4  data inputs; in[k] is channel k.
REQ-006 Port: sel  input  2  channel select, 2'b00..2'b11.
REQ-007 Port: out  output  1  combinational selected bit.
REQ-008 Port: out_q  output  1  registered copy of out.
REQ-009 Port: sel_q  output  2  registered copy of sel.
REQ-010 Port: chg  output  1  one-cycle pulse on a change of the registered output.
REQ-011 Port: clr  input  1  synchronous counter clear.
REQ-012 Port: cnt  output  4*CNT_W  packed counters; channel k occupies cnt[k*CNT_W +: CNT_W].

Function
REQ-013 out SHALL equal in[sel] combinationally, with zero latency, independent of clk and rst.
- Per-channel mapping: sel=00 -> in[0]; 01 -> in[1]; 10 -> in[2]; 11 -> in[3].
REQ-014 out_q SHALL take the value of out at each rising clk edge (1-cycle latency).
REQ-015 sel_q SHALL take the value of sel at each rising clk edge.
REQ-016 chg SHALL be registered as (out != out_q) at each rising clk edge.
- chg is high for exactly one cycle, aligned with the out_q update.
- chg stays low while out is stable.
REQ-017 Input changes between clock edges SHALL affect out immediately and SHALL affect the registered outputs only at the next edge.

Reset
REQ-018 While rst=1, the registered outputs SHALL be forced asynchronously to these values:
- out_q = RESET_VAL.
- sel_q = 2'b00.
- chg = 0.
- All cnt fields = 0.
REQ-019 rst SHALL NOT affect out, which keeps tracking in[sel] during reset.
REQ-020 After rst deasserts mid-operation, the first rising edge SHALL resume the normal updates; chg on that edge compares against RESET_VAL.

Configuration
REQ-021 Macro SELECTOR_FOUR_STATS_EN defined:
- Each rising edge with rst=0 and clr=0 increments the cnt field of channel sel_q by 1.
- Each field saturates at all-ones and does not wrap.
- clr=1 synchronously zeroes all fields.
- When clr and an increment occur on the same edge, the clear wins.
REQ-022 Macro SELECTOR_FOUR_STATS_EN undefined:
- cnt is tied to 0.
- clr is ignored.
- No counter logic is synthesized.
- The port list is identical in both builds.

Verification
REQ-023 Scenario 1 (combinational select): in=4'b1010, sel stepped 00, 01, 10, 11 at 100 ns intervals -> out = 0, 1, 0, 1 immediately after each step.
REQ-024 Scenario 2 (registered path and chg): in=4'b1010, sel changes 00 -> 01 -> out_q goes 0 -> 1 one clock later, chg=1 for that single cycle, sel_q=01.
REQ-025 Scenario 3 (asynchronous reset mid-operation): RESET_VAL=1, out_q=0 and cnt nonzero, rst pulsed between edges -> during the pulse out_q=1, sel_q=00, chg=0, cnt=0 without a clock edge, and out still equals in[sel].
REQ-026 Scenario 4 (stats build, saturation): sel=2'b10 held for 300 cycles with CNT_W=8 -> cnt[23:16]=255 and the other fields=0.
REQ-027 Scenario 5 (stats build, clear): clr=1 on the same edge as an increment -> all fields read 0 after that edge.
REQ-028 Scenario 6 (stats build disabled): 10 cycles of any stimulus -> cnt=0 throughout, and out, out_q and chg behave exactly as in Scenarios 1 and 2.
